beam_pwr_acc: RTL and testbench
===============================

BEAM_PWR_ACC -- requirements
Module: beam_pwr_acc

Interface
REQ-001 SHALL have parameter IW, default 32, meaning width of each real/imag component of the input beam sum.
REQ-002 SHALL have parameter NRE, default 3276, meaning resource elements per symbol (1..65535).
REQ-003 SHALL have parameter SHIFT, default 8, meaning arithmetic right shift applied to each component before saturation.
REQ-004 SHALL have parameter AW, default 48, meaning accumulator and output power width.
REQ-005 SHALL have port i_clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, meaning reset; synchronous and active-low.
REQ-007 SHALL have port i_sum_data, input, 2*IW, meaning beam sum {re[2*IW-1:IW], im[IW-1:0]}, signed two's complement.
REQ-008 SHALL have port i_valid, input, 1, meaning i_sum_data qualifier, one RE per cycle, gaps allowed.
REQ-009 SHALL have port i_sop, input, 1, meaning first RE of a symbol; meaningful only with i_valid.
REQ-010 SHALL have port o_pwr, output, AW, meaning accumulated symbol power, unsigned.
REQ-011 SHALL have port o_pwr_vld, output, 1, meaning single-cycle strobe qualifying o_pwr.
REQ-012 SHALL have port o_sym_cnt, output, 16, meaning count of completed symbols, wraps 0xFFFF->0.
REQ-013 SHALL have port o_err, output, 1, meaning single-cycle pulse on premature i_sop.
REQ-014 SHALL have port o_peak_pwr, output, 32, meaning maximum per-RE power within the last symbol (see REQ-031).

Function
REQ-015 SHALL derive each component as c16 = sat16(c >>> SHIFT), clamping to [-32768, 32767].
REQ-016 SHALL compute per-RE power p = re16^2 + im16^2 as 32-bit unsigned (max 2^31, no overflow).
REQ-017 SHALL implement power as a 3-stage pipeline: saturate register, square registers, sum register.
REQ-018 SHALL add p into a saturating AW-bit accumulator; on overflow it holds 2^AW-1 until symbol end.
REQ-019 SHALL implement FSM states IDLE and ACC; reset enters IDLE.
REQ-020 IDLE: i_valid&i_sop SHALL start a symbol (RE count=1, accumulator seeded with that RE's p) and go to ACC; i_valid without i_sop SHALL be discarded without error.
REQ-021 ACC: i_valid&~i_sop SHALL increment the RE count; the RE making the count equal NRE completes the symbol and returns FSM to IDLE.
REQ-022 ACC: i_valid&i_sop SHALL pulse o_err, drop the partial sum without output, and restart the symbol with that RE (count=1).
REQ-023 NRE=1: every i_valid&i_sop RE SHALL complete a symbol by itself.
REQ-024 o_pwr_vld SHALL pulse exactly 4 cycles after the clock edge sampling a symbol's last RE; o_pwr and o_peak_pwr SHALL be updated in that cycle and then hold.
REQ-025 o_sym_cnt SHALL increment in the same cycle as o_pwr_vld.
REQ-026 A new symbol starting the cycle after a completing RE SHALL be accumulated without loss or stall.

Reset
REQ-027 While i_rst_n=0 at a clock edge: FSM=IDLE, RE count, accumulator, pipeline valids, o_pwr, o_pwr_vld, o_sym_cnt, o_err, o_peak_pwr SHALL all become 0.
REQ-028 Reset mid-symbol SHALL discard the partial symbol with no o_pwr_vld and no o_err; in-flight pipeline samples SHALL be dropped.

Configuration
REQ-029 Macro BEAM_PWR_PEAK_EN SHALL control peak tracking.
REQ-030 Defined: a per-symbol running max of p SHALL be kept, reset to the first RE's p at symbol start, and published on o_peak_pwr with o_pwr_vld.
REQ-031 Undefined: no peak logic SHALL be built; o_peak_pwr SHALL be constant 0.

Structure
REQ-032 Package pusch_pkg SHALL hold the 16-bit saturation limits, the FSM state enum, and the 16-bit symbol-counter width.
REQ-033 Sub-module cmplx_pwr SHALL implement REQ-015..REQ-017 (saturate, square, sum, valid/last pipelining); the top SHALL hold FSM, counter, and accumulator.

Verification
REQ-034 SHIFT=0, NRE=4; 4 contiguous REs re=3, im=4, sop on first -> o_pwr=100, o_pwr_vld 4 cycles after last RE, o_sym_cnt=1.
REQ-035 SHIFT=0, NRE=2; re=im=0x7FFFFFFF twice -> per-RE p=2147352578, o_pwr=4294705156, peak=2147352578 with macro, 0 without.
REQ-036 NRE=4; sop plus 2 REs (p=1), then sop plus 3 REs (p=25) -> one o_err pulse, o_pwr=100, exactly one o_pwr_vld.
REQ-037 NRE=4; REs with i_valid gaps of 0-3 cycles, then next sop the cycle after the last RE -> two correct results, no o_err.
REQ-038 i_rst_n low for 1 cycle after 2 of 4 REs, then a full symbol with p=9 -> only o_pwr=36, o_sym_cnt=1.
REQ-039 AW=32, SHIFT=0, NRE=3, re=im=-32768 -> accumulator saturates, o_pwr=0xFFFFFFFF.

Source files
------------

// File: rtl/pusch_pkg.sv
// ============================================================================
// Module      : pusch_pkg
// Description : Shared saturation limits, FSM state encoding and counter
//               width for the beam power accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pusch_pkg;

    localparam int c_sat_max   = 32767;
    localparam int c_sat_min   = -32768;
    localparam int c_sym_cnt_w = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cmplx_pwr.sv
// ============================================================================
// Module      : cmplx_pwr
// Description : Three-stage |x|^2 pipeline: shift+saturate, square, sum.
//               Valid, first and last tags travel alongside the data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmplx_pwr
    import pusch_pkg::*;
#(
    parameter int IW    = 32,
    parameter int SHIFT = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [2*IW-1:0] i_data,
    input  logic            i_valid,
    input  logic            i_first,
    input  logic            i_last,
    output logic [31:0]     o_pwr,
    output logic            o_valid,
    output logic            o_first,
    output logic            o_last
);

    localparam logic signed [IW-1:0] c_max = IW'(c_sat_max);
    localparam logic signed [IW-1:0] c_min = IW'(c_sat_min);

    function automatic logic signed [15:0] sat16(input logic signed [IW-1:0] v);
        if (v > c_max)      return 16'sh7FFF;
        else if (v < c_min) return -16'sh8000;
        else                return v[15:0];
    endfunction

    logic signed [IW-1:0] w_re_sh;
    logic signed [IW-1:0] w_im_sh;
    logic signed [31:0]   w_re_ext;
    logic signed [31:0]   w_im_ext;
    logic signed [31:0]   w_re_sq;
    logic signed [31:0]   w_im_sq;

    logic signed [15:0]   r_re16;
    logic signed [15:0]   r_im16;
    logic [31:0]          r_re_sq;
    logic [31:0]          r_im_sq;
    logic [31:0]          r_pwr;
    logic [2:0]           r_vld;
    logic [2:0]           r_first;
    logic [2:0]           r_last;

    assign w_re_sh  = $signed(i_data[2*IW-1:IW]) >>> SHIFT;
    assign w_im_sh  = $signed(i_data[IW-1:0]) >>> SHIFT;
    assign w_re_ext = 32'(r_re16);
    assign w_im_ext = 32'(r_im16);
    // Each square is at most 2^30, so the 32-bit sum cannot wrap.
    assign w_re_sq  = w_re_ext * w_re_ext;
    assign w_im_sq  = w_im_ext * w_im_ext;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_re16  <= '0;
            r_im16  <= '0;
            r_re_sq <= '0;
            r_im_sq <= '0;
            r_pwr   <= '0;
            r_vld   <= '0;
            r_first <= '0;
            r_last  <= '0;
        end else begin
            r_re16  <= sat16(w_re_sh);
            r_im16  <= sat16(w_im_sh);
            r_re_sq <= $unsigned(w_re_sq);
            r_im_sq <= $unsigned(w_im_sq);
            r_pwr   <= r_re_sq + r_im_sq;
            r_vld   <= {r_vld[1:0],   i_valid};
            r_first <= {r_first[1:0], i_first};
            r_last  <= {r_last[1:0],  i_last};
        end
    end

    assign o_pwr   = r_pwr;
    assign o_valid = r_vld[2];
    assign o_first = r_first[2];
    assign o_last  = r_last[2];

endmodule

`default_nettype wire

// File: rtl/beam_pwr_acc.sv
// ============================================================================
// Module      : beam_pwr_acc
// Description : Per-symbol beam power accumulator with saturating sum,
//               symbol counter and premature-SOP error. Optional peak
//               tracking enabled by macro BEAM_PWR_PEAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beam_pwr_acc
    import pusch_pkg::*;
#(
    parameter int IW    = 32,
    parameter int NRE   = 3276,
    parameter int SHIFT = 8,
    parameter int AW    = 48
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [2*IW-1:0]        i_sum_data,
    input  logic                   i_valid,
    input  logic                   i_sop,
    output logic [AW-1:0]          o_pwr,
    output logic                   o_pwr_vld,
    output logic [c_sym_cnt_w-1:0] o_sym_cnt,
    output logic                   o_err,
    output logic [31:0]            o_peak_pwr
);

    localparam logic [15:0] c_nre = 16'(NRE);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [15:0]            r_re_cnt;
    logic [15:0]            w_re_cnt_nxt;
    logic [15:0]            w_cnt_inc;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_last;
    logic                   w_err;

    logic [31:0]            w_p;
    logic                   w_p_vld;
    logic                   w_p_first;
    logic                   w_p_last;

    logic [AW:0]            w_sum;
    logic [AW-1:0]          w_acc_sat;
    logic [AW-1:0]          r_acc;
    logic                   r_done;
    logic [AW-1:0]          r_pwr;
    logic                   r_pwr_vld;
    logic [c_sym_cnt_w-1:0] r_sym_cnt;
    logic                   r_err;

    assign w_cnt_inc = r_re_cnt + 16'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_re_cnt_nxt = r_re_cnt;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        w_last       = 1'b0;
        w_err        = 1'b0;
        if (i_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_sop) begin
                        w_accept     = 1'b1;
                        w_start      = 1'b1;
                        w_re_cnt_nxt = 16'd1;
                        if (c_nre == 16'd1) w_last      = 1'b1;
                        else                w_state_nxt = ST_ACC;
                    end
                end
                ST_ACC: begin
                    w_accept = 1'b1;
                    if (i_sop) begin
                        // Restart with this RE; the partial sum is overwritten by the seed.
                        w_err        = 1'b1;
                        w_start      = 1'b1;
                        w_re_cnt_nxt = 16'd1;
                    end else begin
                        w_re_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_nre) begin
                            w_last      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_re_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_re_cnt <= w_re_cnt_nxt;
            r_err    <= w_err;
        end
    end

    cmplx_pwr #(
        .IW    (IW),
        .SHIFT (SHIFT)
    ) u_cmplx_pwr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_sum_data),
        .i_valid (w_accept),
        .i_first (w_start),
        .i_last  (w_last),
        .o_pwr   (w_p),
        .o_valid (w_p_vld),
        .o_first (w_p_first),
        .o_last  (w_p_last)
    );

    assign w_sum     = {1'b0, r_acc} + {1'b0, AW'(w_p)};
    assign w_acc_sat = w_sum[AW] ? {AW{1'b1}} : w_sum[AW-1:0];

    // The completed total sits in r_acc for one cycle, so a symbol seeding
    // r_acc on the same edge as publication does not disturb the output.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_done    <= 1'b0;
            r_pwr     <= '0;
            r_pwr_vld <= 1'b0;
            r_sym_cnt <= '0;
        end else begin
            r_done    <= w_p_vld & w_p_last;
            r_pwr_vld <= r_done;
            if (w_p_vld) r_acc <= w_p_first ? AW'(w_p) : w_acc_sat;
            if (r_done) begin
                r_pwr     <= r_acc;
                r_sym_cnt <= r_sym_cnt + 16'd1;
            end
        end
    end

`ifdef BEAM_PWR_PEAK_EN
    logic [31:0] r_peak;
    logic [31:0] r_peak_out;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_peak     <= '0;
            r_peak_out <= '0;
        end else begin
            if (w_p_vld && (w_p_first || (w_p > r_peak))) r_peak <= w_p;
            if (r_done) r_peak_out <= r_peak;
        end
    end

    assign o_peak_pwr = r_peak_out;
`else
    assign o_peak_pwr = '0;
`endif

    assign o_pwr     = r_pwr;
    assign o_pwr_vld = r_pwr_vld;
    assign o_sym_cnt = r_sym_cnt;
    assign o_err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_beam_pwr_acc.sv
// ============================================================================
// Module      : tb_beam_pwr_acc
// Description : Directed, table-driven bench for beam_pwr_acc over four
//               parameterisations sharing data, SOP and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beam_pwr_acc;

`ifdef BEAM_PWR_PEAK_EN
    localparam logic PK = 1'b1;
`else
    localparam logic PK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] sum_data = '0;
    logic        sop = 1'b0;
    logic [3:0]  vv = '0;

    logic [47:0] pwr_a, pwr_b, pwr_d;
    logic [31:0] pwr_c;
    logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
    logic [31:0] peak_a, peak_b, peak_c, peak_d;
    logic        vld_a, vld_b, vld_c, vld_d;
    logic        err_a, err_b, err_c, err_d;

    always #5 clk = ~clk;

    beam_pwr_acc #(.IW(32), .NRE(4), .SHIFT(0), .AW(48)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_sum_data(sum_data), .i_valid(vv[0]), .i_sop(sop),
        .o_pwr(pwr_a), .o_pwr_vld(vld_a), .o_sym_cnt(cnt_a), .o_err(err_a), .o_peak_pwr(peak_a));
    beam_pwr_acc #(.IW(32), .NRE(2), .SHIFT(0), .AW(48)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_sum_data(sum_data), .i_valid(vv[1]), .i_sop(sop),
        .o_pwr(pwr_b), .o_pwr_vld(vld_b), .o_sym_cnt(cnt_b), .o_err(err_b), .o_peak_pwr(peak_b));
    beam_pwr_acc #(.IW(32), .NRE(3), .SHIFT(0), .AW(32)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_sum_data(sum_data), .i_valid(vv[2]), .i_sop(sop),
        .o_pwr(pwr_c), .o_pwr_vld(vld_c), .o_sym_cnt(cnt_c), .o_err(err_c), .o_peak_pwr(peak_c));
    beam_pwr_acc #(.IW(32), .NRE(1), .SHIFT(8), .AW(48)) dut_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_sum_data(sum_data), .i_valid(vv[3]), .i_sop(sop),
        .o_pwr(pwr_d), .o_pwr_vld(vld_d), .o_sym_cnt(cnt_d), .o_err(err_d), .o_peak_pwr(peak_d));

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          last_edge = 0;
    int          n_vld[4] = '{0, 0, 0, 0};
    int          n_err[4] = '{0, 0, 0, 0};
    int          cap_cyc[4] = '{0, 0, 0, 0};
    logic [63:0] cap_pwr[4];
    logic [63:0] cap_peak[4];
    logic [63:0] cap_cnt[4];
    logic [63:0] q_a[$];
    logic [63:0] q_d[$];

    always @(posedge clk) cyc++;

    // Capture outputs 1 ns after each edge.
    always @(posedge clk) begin
        #1;
        if (vld_a) begin n_vld[0]++; cap_pwr[0] = 64'(pwr_a); cap_peak[0] = 64'(peak_a); cap_cnt[0] = 64'(cnt_a); cap_cyc[0] = cyc; q_a.push_back(64'(pwr_a)); end
        if (vld_b) begin n_vld[1]++; cap_pwr[1] = 64'(pwr_b); cap_peak[1] = 64'(peak_b); cap_cnt[1] = 64'(cnt_b); cap_cyc[1] = cyc; end
        if (vld_c) begin n_vld[2]++; cap_pwr[2] = 64'(pwr_c); cap_peak[2] = 64'(peak_c); cap_cnt[2] = 64'(cnt_c); cap_cyc[2] = cyc; end
        if (vld_d) begin n_vld[3]++; cap_pwr[3] = 64'(pwr_d); cap_peak[3] = 64'(peak_d); cap_cnt[3] = 64'(cnt_d); cap_cyc[3] = cyc; q_d.push_back(64'(pwr_d)); end
        if (err_a) n_err[0]++;
        if (err_b) n_err[1]++;
        if (err_c) n_err[2]++;
        if (err_d) n_err[3]++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic [31:0] re, input logic [31:0] im, input logic s);
        @(negedge clk);
        sum_data  = {re, im};
        sop       = s;
        vv        = '0;
        vv[d]     = 1'b1;
        last_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vv  = '0;
            sop = 1'b0;
        end
    endtask

    task automatic wait_vld(input int d, input int target, input string nm);
        for (int i = 0; i < 40 && n_vld[d] < target; i++) @(negedge clk);
        idle(6);
        chk({nm, "_vld_count"}, 64'(n_vld[d]), 64'(target));
    endtask

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic        sop;
        logic [63:0] exp;
    } vec_t;

    vec_t        tbl[7];
    logic [63:0] exp_q[$];
    int          le;

    initial begin
        tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 64'd1073676289};
        tbl[1] = '{32'hFFFF_FF00, 32'h0000_0500, 1'b1, 64'd26};
        tbl[2] = '{32'h8000_0000, 32'h0000_0000, 1'b1, 64'd1073741824};
        tbl[3] = '{32'h0000_1234, 32'h0000_1234, 1'b0, 64'd0};
        tbl[4] = '{32'h007F_FF00, 32'hFF80_0000, 1'b1, 64'd2147418113};
        tbl[5] = '{32'h0080_0000, 32'hFF7F_FF00, 1'b1, 64'd2147418113};
        tbl[6] = '{32'hFFFF_FF7F, 32'h0000_00FF, 1'b1, 64'd1};

        idle(3);
        chk("rst_pwr_a",  64'(pwr_a), 0);
        chk("rst_vld_a",  64'(vld_a), 0);
        chk("rst_cnt_a",  64'(cnt_a), 0);
        chk("rst_err_a",  64'(err_a), 0);
        chk("rst_peak_a", 64'(peak_a), 0);
        chk("rst_pwr_c",  64'(pwr_c), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic contiguous symbol, p=25 per RE.
        drive(0, 3, 4, 1'b1);
        repeat (3) drive(0, 3, 4, 1'b0);
        le = last_edge;
        idle(1);
        wait_vld(0, 1, "t1");
        chk("t1_pwr",  cap_pwr[0], 100);
        chk("t1_lat",  64'(cap_cyc[0] - le), 4);
        chk("t1_cnt",  cap_cnt[0], 1);
        chk("t1_peak", cap_peak[0], PK ? 64'd25 : 64'd0);
        chk("t1_hold", 64'(pwr_a), 100);
        chk("t1_err",  64'(n_err[0]), 0);

        // Premature SOP drops the partial sum.
        drive(0, 1, 0, 1'b1);
        repeat (2) drive(0, 1, 0, 1'b0);
        drive(0, 3, 4, 1'b1);
        repeat (3) drive(0, 3, 4, 1'b0);
        idle(1);
        wait_vld(0, 2, "t2");
        chk("t2_pwr",  cap_pwr[0], 100);
        chk("t2_err",  64'(n_err[0]), 1);
        chk("t2_cnt",  cap_cnt[0], 2);
        chk("t2_peak", cap_peak[0], PK ? 64'd25 : 64'd0);

        // Gapped REs then a back-to-back symbol.
        drive(0, 1, 0, 1'b1);
        drive(0, 2, 0, 1'b0);
        idle(1);
        drive(0, 3, 0, 1'b0);
        idle(3);
        drive(0, 4, 0, 1'b0);
        drive(0, 0, 6, 1'b1);
        drive(0, 0, 6, 1'b0);
        idle(2);
        drive(0, 0, 6, 1'b0);
        drive(0, 0, 6, 1'b0);
        le = last_edge;
        idle(1);
        wait_vld(0, 4, "t3");
        chk("t3_first",  q_a.size() > 2 ? q_a[2] : 64'hFFFF_FFFF_FFFF_FFFF, 30);
        chk("t3_second", q_a.size() > 3 ? q_a[3] : 64'hFFFF_FFFF_FFFF_FFFF, 144);
        chk("t3_lat",    64'(cap_cyc[0] - le), 4);
        chk("t3_cnt",    cap_cnt[0], 4);
        chk("t3_peak",   cap_peak[0], PK ? 64'd36 : 64'd0);
        chk("t3_err",    64'(n_err[0]), 1);

        // One-cycle reset mid-symbol.
        drive(0, 3, 0, 1'b1);
        drive(0, 3, 0, 1'b0);
        @(negedge clk);
        vv    = '0;
        sop   = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4_rst_pwr", 64'(pwr_a), 0);
        chk("t4_rst_cnt", 64'(cnt_a), 0);
        drive(0, 3, 0, 1'b1);
        repeat (3) drive(0, 3, 0, 1'b0);
        idle(1);
        wait_vld(0, 5, "t4");
        chk("t4_pwr", cap_pwr[0], 36);
        chk("t4_cnt", cap_cnt[0], 1);
        chk("t4_err", 64'(n_err[0]), 1);

        // Full-scale inputs, NRE=2.
        drive(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        drive(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        idle(1);
        wait_vld(1, 1, "t5");
        chk("t5_pwr",  cap_pwr[1], 64'd4294705156);
        chk("t5_peak", cap_peak[1], PK ? 64'd2147352578 : 64'd0);
        chk("t5_cnt",  cap_cnt[1], 1);

        // Accumulator saturation with AW=32.
        drive(2, 32'hFFFF_8000, 32'hFFFF_8000, 1'b1);
        repeat (2) drive(2, 32'hFFFF_8000, 32'hFFFF_8000, 1'b0);
        idle(1);
        wait_vld(2, 1, "t6");
        chk("t6_pwr", cap_pwr[2], 64'hFFFF_FFFF);
        chk("t6_cnt", cap_cnt[2], 1);

        // NRE=1, SHIFT=8: saturation edges; the non-SOP RE is discarded.
        foreach (tbl[i]) begin
            drive(3, tbl[i].re, tbl[i].im, tbl[i].sop);
            if (tbl[i].sop) exp_q.push_back(tbl[i].exp);
        end
        le = last_edge;
        idle(1);
        wait_vld(3, exp_q.size(), "t7");
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("t7_vec%0d", k), q_d.size() > k ? q_d[k] : 64'hFFFF_FFFF_FFFF_FFFF, exp_q[k]);
        chk("t7_cnt",  cap_cnt[3], 64'(exp_q.size()));
        chk("t7_lat",  64'(cap_cyc[3] - le), 4);
        chk("t7_peak", cap_peak[3], PK ? 64'd1 : 64'd0);
        chk("t7_err",  64'(n_err[3]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
